// File: rtl/iua_sample_replay_pkg.sv
// Shared types for the capture replay engine: FSM states, FIFO entry layout, unpack geometry.
package iua_sample_replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_ent_t;

  localparam int FIFO_W = $bits(fifo_ent_t);
  localparam int IDX_W  = 3;

  function automatic int samples_per_byte(input int pk, input int sample_w);
    return (pk != 0) ? (8 / sample_w) : 1;
  endfunction

endpackage

// File: rtl/iua_sample_replay_if.sv
// Byte-stream input and sample output of the replay engine; master = stream source/sample sink.
interface iua_sample_replay_if #(
  parameter int SAMPLE_W = 2
);
  logic [7:0]          in_data;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] out_sample;
  logic                out_valid;
  logic                out_stb;

  modport master (
    output in_data, in_last, in_valid,
    input  in_ready, out_sample, out_valid, out_stb
  );

  modport slave (
    input  in_data, in_last, in_valid,
    output in_ready, out_sample, out_valid, out_stb
  );
endinterface

// File: rtl/iua_sample_replay_fifo.sv
// Generic first-word-fall-through sync FIFO; read data valid same cycle as !empty.
// Pushes are dropped when full and pops when empty; clr_i flushes both pointers.
module iua_sample_replay_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign level_o   = LW'(wr_q - rd_q);
  assign full_o    = (level_o == LW'(DEPTH));
  assign empty_o   = (wr_q == rd_q);
  assign pop_dat_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/iua_sample_replay.sv
// Replays buffered capture bytes as SAMPLE_W-bit line samples at a phase-accumulator rate.
// Samples register on the tick edge; in_ready drops when the byte FIFO is full or during clr.
module iua_sample_replay
  import iua_sample_replay_pkg::*;
#(
  parameter  int SAMPLE_W   = 2,
  parameter  int PACKED     = 0,
  parameter  int FIFO_DEPTH = 16,
  parameter  int PREFILL    = 1,
  parameter  int PHASE_W    = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  iua_sample_replay_if.slave bus,
  input  logic               enable_i,
  input  logic               clr_i,
  input  logic [PHASE_W-1:0] rate_inc_i,
  output logic               underrun_o,
  output logic               done_o,
  output logic [LVL_W-1:0]   level_o
);

  localparam int                SPB       = samples_per_byte(PACKED, SAMPLE_W);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SPB - 1);
  localparam logic [LVL_W-1:0]  PREFILL_L = LVL_W'(PREFILL);

  state_t              state_q;
  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic                rdy_en_q;

  logic [7:0]          byte_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                byte_vld_q, byte_last_q, eos_q;

  logic [SAMPLE_W-1:0] out_sample_q;
  logic                out_valid_q, out_stb_q, underrun_q, done_q;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LVL_W-1:0]    fifo_level;
  fifo_ent_t           fifo_wr, fifo_rd;

  logic [PHASE_W:0]    acc_sum;
  logic                run_go, tick, consume, last_idx;
  logic [7:0]          byte_shift;
  logic [SAMPLE_W-1:0] cur_sample;

  assign bus.in_ready   = rdy_en_q & ~fifo_full & ~clr_i;
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_stb    = out_stb_q;
  assign underrun_o     = underrun_q;
  assign done_o         = done_q;
  assign level_o        = fifo_level;

  assign fifo_push = bus.in_valid & bus.in_ready;
  assign fifo_wr   = {bus.in_last, bus.in_data};

  iua_sample_replay_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .push_i     (fifo_push),
    .push_dat_i (fifo_wr),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_rd),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  // Carry out of the accumulator is the tick; a disabled RUN cycle never ticks.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, rate_inc_i};
  assign acc_d    = acc_sum[PHASE_W-1:0];
  assign run_go   = (state_q == ST_RUN) & enable_i & ~clr_i;
  assign tick     = run_go & acc_sum[PHASE_W];
  assign consume  = tick & byte_vld_q;
  assign last_idx = (idx_q == LAST_IDX);
  assign idx_d    = last_idx ? '0 : idx_q + 1'b1;

  assign byte_shift = byte_q >> ({1'b0, idx_q} * 4'(SAMPLE_W));
  assign cur_sample = byte_shift[SAMPLE_W-1:0];

  // Refill only while running, and never past a last-tagged byte.
  assign fifo_pop = run_go & ~fifo_empty & ~eos_q & ~(byte_vld_q & byte_last_q)
                  & (~byte_vld_q | (consume & last_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q      <= '0;
      idx_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_last_q <= 1'b0;
      eos_q       <= 1'b0;
    end else if (clr_i) begin
      byte_q      <= '0;
      idx_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_last_q <= 1'b0;
      eos_q       <= 1'b0;
    end else if (fifo_pop) begin
      byte_q      <= fifo_rd.data;
      byte_last_q <= fifo_rd.last;
      byte_vld_q  <= 1'b1;
      idx_q       <= '0;
    end else if (consume) begin
      idx_q <= idx_d;
      if (last_idx) begin
        byte_vld_q <= 1'b0;
        eos_q      <= byte_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_stb_q    <= 1'b0;
      underrun_q   <= 1'b0;
      done_q       <= 1'b0;
    end else if (clr_i) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_stb_q    <= 1'b0;
      underrun_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      out_stb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          acc_q        <= '0;
          out_sample_q <= '0;
          out_valid_q  <= 1'b0;
          if (enable_i && (fifo_level >= PREFILL_L)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_stb_q    <= 1'b1;
          end else begin
            acc_q <= acc_d;
            if (tick) begin
              out_stb_q <= 1'b1;
              if (byte_vld_q) begin
                out_sample_q <= cur_sample;
                out_valid_q  <= 1'b1;
              end else if (eos_q) begin
                state_q      <= ST_DONE;
                acc_q        <= '0;
                done_q       <= 1'b1;
                out_sample_q <= '0;
                out_valid_q  <= 1'b0;
              end else begin
                underrun_q   <= 1'b1;
                out_sample_q <= '0;
                out_valid_q  <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          acc_q        <= '0;
          done_q       <= 1'b1;
          out_sample_q <= '0;
          out_valid_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          acc_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iua_sample_replay.sv
// Directed bench: unpacked instance (A) and packed instance (B), both SAMPLE_W=2, depth 16.
module tb_iua_sample_replay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, clr_a = 1'b0, en_b = 1'b0, clr_b = 1'b0;
  logic [15:0] rate_a = '0, rate_b = '0;
  logic        underrun_a, done_a, underrun_b, done_b;
  logic [4:0]  level_a, level_b;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  iua_sample_replay_if #(.SAMPLE_W(2)) if_a ();
  iua_sample_replay_if #(.SAMPLE_W(2)) if_b ();

  iua_sample_replay #(.SAMPLE_W(2), .PACKED(0), .FIFO_DEPTH(16), .PREFILL(1), .PHASE_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .enable_i(en_a), .clr_i(clr_a),
    .rate_inc_i(rate_a), .underrun_o(underrun_a), .done_o(done_a), .level_o(level_a));

  iua_sample_replay #(.SAMPLE_W(2), .PACKED(1), .FIFO_DEPTH(16), .PREFILL(1), .PHASE_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .enable_i(en_b), .clr_i(clr_b),
    .rate_inc_i(rate_b), .underrun_o(underrun_b), .done_o(done_b), .level_o(level_b));

  task automatic push_a(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    if_a.in_data = d; if_a.in_last = l; if_a.in_valid = 1'b1;
    while (!if_a.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!if_a.in_ready) begin
      checks++;
      $display("FAIL push_a_timeout: in_ready got 0 required 1 (byte %0h)", d);
    end else begin
      @(posedge clk);
    end
    #1 if_a.in_valid = 1'b0;
  endtask

  task automatic wait_stb(input int sel, input int max_cyc, output int cyc);
    logic s;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      s = (sel == 0) ? if_a.out_stb : if_b.out_stb;
    end while (!s && cyc < max_cyc);
    if (!s) begin
      checks++;
      $display("FAIL stb_timeout: dut %0d no out_stb within %0d cycles", sel, max_cyc);
    end
  endtask

  task automatic pulse_clr_a();
    @(negedge clk); clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (if_a.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b required 0", if_a.in_ready); else passed++;
    checks++; if ({if_a.out_valid, if_a.out_stb, if_a.out_sample} !== 4'b0) $display("FAIL rst_outs: got %0h required 0", {if_a.out_valid, if_a.out_stb, if_a.out_sample}); else passed++;
    checks++; if ({done_a, underrun_a, level_a} !== 7'b0) $display("FAIL rst_flags: got %0h required 0", {done_a, underrun_a, level_a}); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (if_a.in_ready !== 1'b0) $display("FAIL rel_in_ready_early: got %0b required 0", if_a.in_ready); else passed++;
    @(posedge clk); #1;
    checks++; if (if_a.in_ready !== 1'b1) $display("FAIL rel_in_ready: got %0b required 1", if_a.in_ready); else passed++;
    checks++; if (if_b.in_ready !== 1'b1) $display("FAIL rel_in_ready_b: got %0b required 1", if_b.in_ready); else passed++;
  endtask

  task automatic test_basic_stream();
    logic [1:0] exp_s [3] = '{2'd3, 2'd1, 2'd2};
    int cyc;
    rate_a = 16'h8000;
    push_a(8'h03, 1'b0); push_a(8'h01, 1'b0); push_a(8'h02, 1'b1);
    @(negedge clk);
    checks++; if (level_a !== 5'd3) $display("FAIL basic_level: got %0d required 3", level_a); else passed++;
    en_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_stb(0, 20, cyc);
      checks++; if (cyc !== ((k == 0) ? 3 : 2)) $display("FAIL basic_gap%0d: got %0d required %0d", k, cyc, (k == 0) ? 3 : 2); else passed++;
      checks++; if ({if_a.out_valid, if_a.out_sample} !== {1'b1, exp_s[k]}) $display("FAIL basic_sample%0d: got %0h required %0h", k, {if_a.out_valid, if_a.out_sample}, {1'b1, exp_s[k]}); else passed++;
    end
    wait_stb(0, 20, cyc);
    checks++; if ({done_a, if_a.out_valid, if_a.out_sample, underrun_a} !== 5'b10000) $display("FAIL basic_done: got %0b required 10000", {done_a, if_a.out_valid, if_a.out_sample, underrun_a}); else passed++;
    checks++; if (cyc !== 2) $display("FAIL basic_done_gap: got %0d required 2", cyc); else passed++;
    pulse_clr_a();
    en_a = 1'b0;
    #1;
    checks++; if ({done_a, level_a} !== 6'b0) $display("FAIL basic_clr: got %0h required 0", {done_a, level_a}); else passed++;
  endtask

  task automatic test_packed();
    int cyc, n = 0;
    rate_b = 16'h8000;
    @(negedge clk);
    if_b.in_data = 8'hE4; if_b.in_last = 1'b1; if_b.in_valid = 1'b1;
    while (!if_b.in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 if_b.in_valid = 1'b0;
    @(negedge clk); en_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_stb(1, 20, cyc);
      checks++; if ({if_b.out_valid, if_b.out_sample} !== {1'b1, 2'(k)}) $display("FAIL packed_sample%0d: got %0h required %0h", k, {if_b.out_valid, if_b.out_sample}, {1'b1, 2'(k)}); else passed++;
    end
    wait_stb(1, 20, cyc);
    checks++; if ({done_b, if_b.out_valid, underrun_b} !== 3'b100) $display("FAIL packed_done: got %0b required 100", {done_b, if_b.out_valid, underrun_b}); else passed++;
    @(negedge clk); en_b = 1'b0;
  endtask

  task automatic test_underrun();
    int cyc = 0;
    rate_a = 16'h8000;
    push_a(8'h01, 1'b0);
    @(negedge clk); en_a = 1'b1;
    wait_stb(0, 20, cyc);
    checks++; if ({if_a.out_valid, if_a.out_sample} !== 3'b101) $display("FAIL ur_first: got %0b required 101", {if_a.out_valid, if_a.out_sample}); else passed++;
    wait_stb(0, 20, cyc);
    checks++; if ({underrun_a, if_a.out_valid, if_a.out_sample} !== 4'b1000) $display("FAIL ur_flag: got %0b required 1000", {underrun_a, if_a.out_valid, if_a.out_sample}); else passed++;
    push_a(8'h02, 1'b0);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!(if_a.out_stb && if_a.out_valid) && cyc < 20);
    checks++; if ({if_a.out_valid, if_a.out_sample, underrun_a} !== 4'b1101) $display("FAIL ur_resume: got %0b required 1101", {if_a.out_valid, if_a.out_sample, underrun_a}); else passed++;
    pulse_clr_a();
    en_a = 1'b0;
    #1;
    checks++; if (underrun_a !== 1'b0) $display("FAIL ur_clr: got %0b required 0", underrun_a); else passed++;
  endtask

  task automatic test_full();
    int n = 0, stbs = 0;
    rate_a = 16'h0000;
    for (int i = 0; i < 16; i++) push_a(8'(i + 16), 1'b0);
    @(negedge clk);
    checks++; if ({level_a, if_a.in_ready} !== {5'd16, 1'b0}) $display("FAIL full_level: got %0h required %0h", {level_a, if_a.in_ready}, {5'd16, 1'b0}); else passed++;
    if_a.in_data = 8'hAA; if_a.in_last = 1'b0; if_a.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (level_a !== 5'd16) $display("FAIL full_hold: got %0d required 16", level_a); else passed++;
    en_a = 1'b1;
    while (!if_a.in_ready && n < 10) begin @(negedge clk); n++; end
    checks++; if (n !== 2) $display("FAIL full_drain_lat: got %0d required 2", n); else passed++;
    @(posedge clk); #1 if_a.in_valid = 1'b0;
    checks++; if ({level_a, if_a.in_ready} !== {5'd16, 1'b0}) $display("FAIL full_refill: got %0h required %0h", {level_a, if_a.in_ready}, {5'd16, 1'b0}); else passed++;
    repeat (6) begin @(posedge clk); #1; if (if_a.out_stb) stbs++; end
    checks++; if (stbs !== 0) $display("FAIL rate0_stb: got %0d required 0", stbs); else passed++;
    @(negedge clk); en_a = 1'b0;
    @(posedge clk); #1;
    checks++; if ({if_a.out_stb, if_a.out_valid, level_a} !== {1'b1, 1'b0, 5'd16}) $display("FAIL disable_stb: got %0h required %0h", {if_a.out_stb, if_a.out_valid, level_a}, {1'b1, 1'b0, 5'd16}); else passed++;
    pulse_clr_a();
    #1;
    checks++; if (level_a !== 5'd0) $display("FAIL full_clr: got %0d required 0", level_a); else passed++;
  endtask

  task automatic test_async_reset();
    int cyc;
    rate_a = 16'h8000;
    push_a(8'h01, 1'b0); push_a(8'h02, 1'b0); push_a(8'h03, 1'b0);
    @(negedge clk); en_a = 1'b1;
    wait_stb(0, 20, cyc);
    checks++; if ({if_a.out_stb, if_a.out_valid, if_a.out_sample} !== 4'b1101) $display("FAIL ar_pre: got %0b required 1101", {if_a.out_stb, if_a.out_valid, if_a.out_sample}); else passed++;
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({if_a.out_stb, if_a.out_valid, if_a.out_sample, if_a.in_ready, level_a} !== 10'b0) $display("FAIL ar_now: got %0h required 0", {if_a.out_stb, if_a.out_valid, if_a.out_sample, if_a.in_ready, level_a}); else passed++;
    en_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({if_a.in_ready, level_a, if_a.out_stb, done_a, underrun_a} !== {1'b1, 5'd0, 3'b000}) $display("FAIL ar_after: got %0h required %0h", {if_a.in_ready, level_a, if_a.out_stb, done_a, underrun_a}, {1'b1, 5'd0, 3'b000}); else passed++;
  endtask

  task automatic test_full_rate();
    int stbs = 0;
    logic ur_seen = 1'b0;
    rate_a = 16'hFFFF;
    @(negedge clk);
    if_a.in_data = 8'h5A; if_a.in_last = 1'b0; if_a.in_valid = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (level_a !== 5'd16) $display("FAIL fr_prefill: got %0d required 16", level_a); else passed++;
    en_a = 1'b1;
    // First edge moves IDLE->RUN, then 65536 RUN cycles.
    repeat (65537) begin
      @(posedge clk); #1;
      if (if_a.out_stb) stbs++;
      if (underrun_a) ur_seen = 1'b1;
    end
    checks++; if (stbs !== 65535) $display("FAIL fr_stb_count: got %0d required 65535", stbs); else passed++;
    checks++; if ({ur_seen, if_a.out_valid, if_a.out_sample} !== 4'b0110) $display("FAIL fr_supply: got %0b required 0110", {ur_seen, if_a.out_valid, if_a.out_sample}); else passed++;
    @(negedge clk); en_a = 1'b0; if_a.in_valid = 1'b0;
  endtask

  initial begin
    if_a.in_data = '0; if_a.in_last = 1'b0; if_a.in_valid = 1'b0;
    if_b.in_data = '0; if_b.in_last = 1'b0; if_b.in_valid = 1'b0;
    test_reset();
    test_basic_stream();
    test_packed();
    test_underrun();
    test_full();
    test_async_reset();
    test_full_rate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
